// File: rtl/uart_tx.sv
// UART transmitter: valid/ready word input, one-word holding buffer, LSB-first serial frames.
// Define UART_TX_PARITY_EN to append an even-parity bit after the data bits.
module uart_tx #(
    parameter int unsigned CLOCK_FREQ = 50_000_000,
    parameter int unsigned BAUD_RATE  = 115_200,
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned STOP_BITS  = 1
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic [WIDTH-1:0] data,
    input  logic             valid,
    output logic             ready,
    output logic             tx,
    output logic             busy
);

    localparam int unsigned TPB   = CLOCK_FREQ / BAUD_RATE;
    localparam int unsigned CNT_W = $clog2(TPB) + 1;
    localparam int unsigned IDX_W = $clog2(WIDTH + 2);

    if (TPB < 2) begin : g_tpb_check
        $error("uart_tx: CLOCK_FREQ / BAUD_RATE must be at least 2");
    end

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t             state, state_n;
    logic [CNT_W-1:0]   tick, tick_n;
    logic [IDX_W-1:0]   bit_idx, bit_idx_n;
    logic [WIDTH-1:0]   shifter, shifter_n;
    logic [WIDTH-1:0]   buffer, buffer_n;
    logic               buffer_full, buffer_full_n;
    logic               tx_n, busy_n, ready_n;
    logic               accept_c, load_c;
`ifdef UART_TX_PARITY_EN
    logic               parity_bit, parity_n;
`endif

    assign accept_c = valid && ready;

    // State and output registers
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state       <= IDLE;
            tick        <= '0;
            bit_idx     <= '0;
            shifter     <= '0;
            buffer      <= '0;
            buffer_full <= 1'b0;
            tx          <= 1'b1;
            busy        <= 1'b0;
            ready       <= 1'b1;
`ifdef UART_TX_PARITY_EN
            parity_bit  <= 1'b0;
`endif
        end else begin
            state       <= state_n;
            tick        <= tick_n;
            bit_idx     <= bit_idx_n;
            shifter     <= shifter_n;
            buffer      <= buffer_n;
            buffer_full <= buffer_full_n;
            tx          <= tx_n;
            busy        <= busy_n;
            ready       <= ready_n;
`ifdef UART_TX_PARITY_EN
            parity_bit  <= parity_n;
`endif
        end
    end

    // Next-state, buffer handling and registered-output precompute
    always_comb begin
        state_n       = state;
        tick_n        = tick;
        bit_idx_n     = bit_idx;
        shifter_n     = shifter;
        buffer_n      = buffer;
        buffer_full_n = buffer_full;
        load_c        = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_n      = parity_bit;
`endif

        case (state)
            IDLE: begin
                if (buffer_full) begin
                    load_c = 1'b1;
                end
            end
            START: begin
                if (tick == '0) begin
                    state_n   = DATA;
                    tick_n    = CNT_W'(TPB - 1);
                    bit_idx_n = '0;
                end else begin
                    tick_n = tick - CNT_W'(1);
                end
            end
            DATA: begin
                if (tick == '0) begin
                    shifter_n = shifter >> 1;
                    tick_n    = CNT_W'(TPB - 1);
                    if (bit_idx == IDX_W'(WIDTH - 1)) begin
                        bit_idx_n = '0;
`ifdef UART_TX_PARITY_EN
                        state_n   = PARITY;
`else
                        state_n   = STOP;
`endif
                    end else begin
                        bit_idx_n = bit_idx + IDX_W'(1);
                    end
                end else begin
                    tick_n = tick - CNT_W'(1);
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (tick == '0) begin
                    state_n   = STOP;
                    tick_n    = CNT_W'(TPB - 1);
                    bit_idx_n = '0;
                end else begin
                    tick_n = tick - CNT_W'(1);
                end
            end
`endif
            STOP: begin
                if (tick == '0) begin
                    if (bit_idx == IDX_W'(STOP_BITS - 1)) begin
                        bit_idx_n = '0;
                        if (buffer_full) begin
                            load_c = 1'b1;
                        end else begin
                            state_n = IDLE;
                        end
                    end else begin
                        bit_idx_n = bit_idx + IDX_W'(1);
                        tick_n    = CNT_W'(TPB - 1);
                    end
                end else begin
                    tick_n = tick - CNT_W'(1);
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        // Buffer-to-shifter transfer starts a new frame
        if (load_c) begin
            state_n       = START;
            tick_n        = CNT_W'(TPB - 1);
            bit_idx_n     = '0;
            shifter_n     = buffer;
            buffer_full_n = 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_n      = ^buffer;
`endif
        end

        // ready is low while full and stays low the cycle after a transfer
        if (accept_c) begin
            buffer_n      = data;
            buffer_full_n = 1'b1;
        end
        ready_n = !(buffer_full || accept_c);
        busy_n  = (state_n != IDLE);

        case (state_n)
            START:   tx_n = 1'b0;
            DATA:    tx_n = shifter_n[0];
`ifdef UART_TX_PARITY_EN
            PARITY:  tx_n = parity_n;
`endif
            default: tx_n = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_uart_tx.sv
// Testbench for uart_tx: two instances (STOP_BITS 1 and 2), TPB=10, WIDTH=8,
// each checked every cycle against a queue-based line model, plus literal frame checks.
module tb_uart_tx;

    localparam int TPB = 10;
`ifdef UART_TX_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif

    logic       clock = 1'b0;
    logic       resetn = 1'b0;
    logic       valid [2];
    logic [7:0] data  [2];
    logic       ready [2];
    logic       tx    [2];
    logic       busy  [2];

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : g_inst
        localparam int SB = g + 1;
        logic       line_q [$];
        logic [7:0] hold = 8'h00;
        logic       hold_v = 1'b0;
        logic       exp_tx = 1'b1;
        logic       exp_busy = 1'b0;
        logic       exp_ready = 1'b1;
        logic       acc, xfer, fbit;

        uart_tx #(
            .CLOCK_FREQ(100),
            .BAUD_RATE (10),
            .WIDTH     (8),
            .STOP_BITS (SB)
        ) u_dut (
            .clock (clock),
            .resetn(resetn),
            .data  (data[g]),
            .valid (valid[g]),
            .ready (ready[g]),
            .tx    (tx[g]),
            .busy  (busy[g])
        );

        // Line model: a queue of per-cycle line values for the frame in flight
        always @(posedge clock or negedge resetn) begin
            if (!resetn) begin
                line_q.delete();
                hold_v    = 1'b0;
                exp_tx    = 1'b1;
                exp_busy  = 1'b0;
                exp_ready = 1'b1;
            end else begin
                acc  = valid[g] && exp_ready;
                xfer = 1'b0;
                if (line_q.size() == 0 && hold_v) begin
                    for (int b = 0; b < 1 + 8 + P + SB; b++) begin
                        if (b == 0)                fbit = 1'b0;
                        else if (b <= 8)           fbit = hold[b-1];
                        else if (b == 9 && P == 1) fbit = ^hold;
                        else                       fbit = 1'b1;
                        repeat (TPB) line_q.push_back(fbit);
                    end
                    hold_v = 1'b0;
                    xfer   = 1'b1;
                end
                if (line_q.size() != 0) begin
                    exp_tx   = line_q.pop_front();
                    exp_busy = 1'b1;
                end else begin
                    exp_tx   = 1'b1;
                    exp_busy = 1'b0;
                end
                exp_ready = !(hold_v || acc || xfer);
                if (acc) begin
                    hold   = data[g];
                    hold_v = 1'b1;
                end
            end
        end

        always @(posedge clock) begin
            #2;
            check($sformatf("tx[%0d]", g),    32'(tx[g]),    32'(exp_tx));
            check($sformatf("busy[%0d]", g),  32'(busy[g]),  32'(exp_busy));
            check($sformatf("ready[%0d]", g), 32'(ready[g]), 32'(exp_ready));
        end
    end

    // Send one word from idle and check the recorded frame against literal bits
    task automatic run_frame(input int g, input logic [7:0] w, input int eb[12],
                             input int nb, input int sb, input string tag);
        logic rtx [160];
        logic rbusy [160];
        logic rrdy [160];
        int   bc, oc;
        data[g]  = w;
        valid[g] = 1'b1;
        @(posedge clock);
        @(negedge clock);
        valid[g] = 1'b0;
        for (int n = 0; n < 160; n++) begin
            rtx[n]   = tx[g];
            rbusy[n] = busy[g];
            rrdy[n]  = ready[g];
            @(negedge clock);
        end
        check($sformatf("%s_idle_at_accept", tag), 32'(rtx[0]), 32'd1);
        check($sformatf("%s_busy_at_accept", tag), 32'(rbusy[0]), 32'd0);
        check($sformatf("%s_start_edge", tag), 32'(rtx[1]), 32'd0);
        for (int k = 0; k < nb; k++)
            check($sformatf("%s_bit%0d", tag, k), 32'(rtx[1 + TPB * k + 5]), 32'(eb[k]));
        bc = 0;
        for (int n = 0; n < 160; n++) if (rbusy[n]) bc++;
        check($sformatf("%s_busy_cycles", tag), 32'(bc), 32'(nb * TPB));
        check($sformatf("%s_busy_first", tag), 32'(rbusy[1]), 32'd1);
        check($sformatf("%s_busy_last", tag), 32'(rbusy[nb * TPB]), 32'd1);
        check($sformatf("%s_busy_after", tag), 32'(rbusy[nb * TPB + 1]), 32'd0);
        check($sformatf("%s_ready_low", tag), 32'(rrdy[1]), 32'd0);
        check($sformatf("%s_ready_back", tag), 32'(rrdy[2]), 32'd1);
        oc = 0;
        for (int n = 1 + TPB * (nb - sb); n <= nb * TPB; n++) if (rtx[n]) oc++;
        check($sformatf("%s_stop_high", tag), 32'(oc), 32'(sb * TPB));
    endtask

    initial begin
        int   eb [12];
        int   bc;
        logic rbusy [260];
        logic rrdy  [260];
        logic rtx   [260];
        int   fl;

        // Reset with valid asserted: nothing may be accepted
        valid[0] = 1'b1; valid[1] = 1'b1;
        data[0]  = 8'h96; data[1] = 8'h69;
        repeat (5) @(negedge clock);
        check("reset_tx",    32'(tx[0]),    32'd1);
        check("reset_ready", 32'(ready[1]), 32'd1);
        check("reset_busy",  32'(busy[0]),  32'd0);
        valid[0] = 1'b0; valid[1] = 1'b0;
        resetn   = 1'b1;
        repeat (3) @(negedge clock);

        // Single frames
`ifdef UART_TX_PARITY_EN
        eb = '{0,1,0,1,0,0,1,0,1,0,1,0};
        run_frame(0, 8'hA5, eb, 11, 1, "a5");
        eb = '{0,1,1,1,0,0,0,0,0,1,1,0};
        run_frame(0, 8'h07, eb, 11, 1, "p07");
        eb = '{0,0,0,1,1,1,1,0,0,0,1,1};
        run_frame(1, 8'h3C, eb, 12, 2, "s2_3c");
`else
        eb = '{0,1,0,1,0,0,1,0,1,1,0,0};
        run_frame(0, 8'hA5, eb, 10, 1, "a5");
        eb = '{0,0,0,1,1,1,1,0,0,1,1,0};
        run_frame(1, 8'h3C, eb, 11, 2, "s2_3c");
`endif

        // Back-to-back: second word accepted during the first frame
        fl = (1 + 8 + P + 1) * TPB;
        data[0]  = 8'h00;
        valid[0] = 1'b1;
        @(posedge clock);
        @(negedge clock);
        valid[0] = 1'b0;
        for (int n = 0; n < 260; n++) begin
            rtx[n] = tx[0]; rbusy[n] = busy[0]; rrdy[n] = ready[0];
            if (n == 5) begin data[0] = 8'hFF; valid[0] = 1'b1; end
            if (n == 6) valid[0] = 1'b0;
            @(negedge clock);
        end
        bc = 0;
        for (int n = 0; n < 260; n++) if (rbusy[n]) bc++;
        check("b2b_busy_cycles", 32'(bc), 32'(2 * fl));
        check("b2b_no_gap_busy", 32'(rbusy[fl + 1]), 32'd1);
        check("b2b_last_stop",   32'(rtx[fl]), 32'd1);
        check("b2b_next_start",  32'(rtx[fl + 1]), 32'd0);
        check("b2b_ready_held",  32'(rrdy[fl]), 32'd0);
        check("b2b_ready_xfer",  32'(rrdy[fl + 1]), 32'd0);
        check("b2b_ready_back",  32'(rrdy[fl + 2]), 32'd1);

        // Mid-frame reset during data bit 3 with a word buffered
        data[0]  = 8'h00;
        valid[0] = 1'b1;
        @(posedge clock);
        @(negedge clock);
        data[0] = 8'hC3;
        for (int n = 0; n < 45; n++) begin
            if (n == 3) valid[0] = 1'b0;
            @(negedge clock);
        end
        check("mid_bit3_low", 32'(tx[0]), 32'd0);
        resetn = 1'b0;
        #1;
        check("mid_rst_tx",    32'(tx[0]),    32'd1);
        check("mid_rst_busy",  32'(busy[0]),  32'd0);
        check("mid_rst_ready", 32'(ready[0]), 32'd1);
        repeat (3) @(negedge clock);
        resetn = 1'b1;
        repeat (5) @(negedge clock);
        check("mid_discarded", 32'(busy[0]), 32'd0);
`ifdef UART_TX_PARITY_EN
        eb = '{0,0,1,0,1,1,0,1,0,0,1,0};
        run_frame(0, 8'h5A, eb, 11, 1, "post_rst");
`else
        eb = '{0,0,1,0,1,1,0,1,0,1,0,0};
        run_frame(0, 8'h5A, eb, 10, 1, "post_rst");
`endif

        // Random traffic with one reset in the middle
        for (int cyc = 0; cyc < 4000; cyc++) begin
            for (int g = 0; g < 2; g++) begin
                valid[g] = ($urandom_range(0, 3) == 0);
                data[g]  = 8'($urandom);
            end
            if (cyc == 2000) resetn = 1'b0;
            if (cyc == 2003) resetn = 1'b1;
            @(negedge clock);
        end
        valid[0] = 1'b0; valid[1] = 1'b0;
        repeat (300) @(negedge clock);
        check("final_idle_tx0", 32'(tx[0]),   32'd1);
        check("final_idle_bs1", 32'(busy[1]), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
# uart_tx

UART transmitter: accepts parallel words over a valid/ready handshake and serialises them LSB-first onto the asynchronous serial line. Each frame is one start bit, WIDTH data bits, an optional parity bit, and STOP_BITS stop bits. A one-word holding buffer allows back-to-back frames with no idle gap between them. The block sits between the design's word producer (FIFO or controller) and the TX pad, and pairs with the design's UART receiver.

## Interface
- CLOCK_FREQ, 50_000_000, system clock frequency in Hz
- BAUD_RATE, 115_200, line bit rate in bits/s
- WIDTH, 8, data bits per frame (1..16)
- STOP_BITS, 1, stop bits per frame (1 or 2)

- clock  in  1  system clock, rising edge
- resetn  in  1  reset, asynchronous, active-low
- data  in  WIDTH  word to transmit; sampled when valid && ready
- valid  in  1  producer has a word on data
- ready  out  1  holding buffer empty; a word can be accepted this cycle
- tx  out  1  serial line; idle high
- busy  out  1  a frame is being shifted out (start bit through last stop bit)

## Operation
- Bit period: TPB = CLOCK_FREQ / BAUD_RATE, truncating integer division. TPB must be at least 2; a smaller value is a configuration error.
- Tick counter width is $clog2(TPB)+1. The counter loads TPB-1 at the start of each bit and decrements to 0. The bit ends on the cycle the counter reads 0.
- Holding buffer (one entry):
  - A word is written on any edge where valid && ready.
  - ready = !buffer_full, registered.
- State machine: IDLE, START, DATA, PARITY (present only with the macro), STOP.
  - IDLE: tx=1, busy=0. If buffer_full, load the shifter from the buffer, clear buffer_full, and go to START.
  - START: tx=0 for TPB cycles, then go to DATA with bit index 0.
  - DATA: tx=shifter[0] for TPB cycles per bit. The shifter shifts right after each bit. After bit WIDTH-1, go to PARITY if present, otherwise STOP.
  - PARITY: tx=parity bit for TPB cycles, then go to STOP.
  - STOP: tx=1 for STOP_BITS*TPB cycles. At the end of the stop period:
    - If buffer_full, load the shifter and go directly to START (back-to-back).
    - Otherwise go to IDLE.
- Simultaneous buffer write and buffer-to-shifter transfer cannot occur, because ready=0 while buffer_full.
- The buffer is written while a frame is in flight. The word in flight is never disturbed by a new accept.
- Reset (asynchronous, any time including mid-frame) forces: state=IDLE, tx=1, busy=0, ready=1, buffer_full=0, counters=0. The partial frame is abandoned.

## Timing
- Reset values: tx=1, ready=1, busy=0.
- Accept at edge N with the block in IDLE: buffer_full=1 and ready=0 after edge N. Then at edge N+1: tx=0 and busy=1.
- ready returns to 1 the cycle after the buffer transfers to the shifter.
- Frame length: (1 + WIDTH + P + STOP_BITS) * TPB cycles, where P=1 with parity, otherwise 0.
- Back-to-back: the next start bit begins on the cycle immediately following the last stop-bit cycle, with zero idle cycles.
- tx is driven from a register, so there are no combinational glitches on the line.

## Configuration
- UART_TX_PARITY_EN defined:
  - PARITY state is compiled in.
  - Parity bit = even parity, i.e. XOR of the WIDTH data bits; the bit is 1 when the data has an odd count of ones.
  - Frame gains one bit period.
- Undefined: the PARITY state and its logic are absent; DATA goes straight to STOP.

## Test plan
- Reset: assert resetn=0 with valid=1 -> tx=1, ready=1, busy=0 throughout; no word accepted.
- Single frame: CLOCK_FREQ=100, BAUD_RATE=10 (TPB=10), WIDTH=8, send 0xA5 -> tx holds each of 0,1,0,1,0,0,1,0,1,1 for 10 cycles. The start bit begins 1 cycle after accept; busy is high for 100 cycles; ready re-asserts 2 cycles after accept.
- Back-to-back: send 0x00 then 0xFF, with the second word accepted during the first frame -> 200 contiguous busy cycles, no idle high gap between the stop bit and the second start bit, and ready held low between the second accept and its transfer.
- Parity (UART_TX_PARITY_EN): send 0x07 -> parity bit 1, frame 110 cycles. Send 0xA5 -> parity bit 0.
- STOP_BITS=2: send 0x3C -> the stop period holds tx=1 for 20 cycles before IDLE or the next start bit.
- Mid-frame reset: pulse resetn low during DATA bit 3 -> tx=1 immediately (asynchronous), the buffered word is discarded, and after release the next accepted word transmits as a complete, correct frame.
